// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module : clk_div_pkg
// Brief  : Shared state encoding and default constants for clk_div_detect.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package clk_div_pkg;

    localparam int c_CNT_W_DEFAULT    = 8;
    localparam int c_LOCK_CNT_DEFAULT = 4;
    localparam int c_MATCH_W          = 4;

    typedef enum logic [1:0] {
        ST_SEEK = 2'd0,
        ST_MEAS = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    // Saturating increment of the consecutive-match counter.
    function automatic logic [c_MATCH_W-1:0] match_inc(
        input logic [c_MATCH_W-1:0] cnt,
        input logic [c_MATCH_W-1:0] limit
    );
        if (cnt >= limit) begin
            return limit;
        end
        return cnt + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module : sync_edge
// Brief  : Two-flop synchronizer plus history flop giving a one-cycle rise.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic clk_in,
    output logic sync,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_hist;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_hist <= 1'b0;
        end else begin
            r_meta <= clk_in;
            r_sync <= r_meta;
            r_hist <= r_sync;
        end
    end

    assign sync = r_sync;
    assign rise = r_sync & ~r_hist;

endmodule

`default_nettype wire

// File: rtl/clk_div_detect.sv
// ============================================================================
// Module : clk_div_detect
// Brief  : Measures period/high time of a divided clock and reports lock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module clk_div_detect
    import clk_div_pkg::*;
#(
    parameter int CNT_W    = c_CNT_W_DEFAULT,
    parameter int LOCK_CNT = c_LOCK_CNT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             sat_err
);

    localparam logic [CNT_W-1:0]     c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0]     c_CNT_ONE  = CNT_W'(1);
    localparam logic [c_MATCH_W-1:0] c_LOCK_M   = c_MATCH_W'(LOCK_CNT);
    localparam logic [c_MATCH_W-1:0] c_MATCH_1  = c_MATCH_W'(1);

    logic                 w_sync;
    logic                 w_rise;

    state_t               r_state;
    logic [CNT_W-1:0]     r_per_cnt;
    logic [CNT_W-1:0]     r_high_cnt;
    logic [c_MATCH_W-1:0] r_match_cnt;
    logic [CNT_W-1:0]     r_period;
    logic [CNT_W-1:0]     r_high_time;
    logic                 r_meas_valid;
    logic                 r_locked;
    logic                 r_sat_err;

    state_t               w_state_nxt;
    logic [CNT_W-1:0]     w_per_cnt_nxt;
    logic [CNT_W-1:0]     w_high_cnt_nxt;
    logic [c_MATCH_W-1:0] w_match_cnt_nxt;
    logic [c_MATCH_W-1:0] w_match_inc;
    logic [CNT_W-1:0]     w_period_nxt;
    logic [CNT_W-1:0]     w_high_time_nxt;
    logic                 w_meas_valid_nxt;
    logic                 w_locked_nxt;
    logic                 w_sat_err_nxt;
    logic                 w_per_sat;
    logic                 w_same;

    sync_edge u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .clk_in (clk_in),
        .sync   (w_sync),
        .rise   (w_rise)
    );

    assign w_per_sat   = (r_per_cnt == c_CNT_MAX);
    assign w_same      = (r_per_cnt == r_period) && (r_high_cnt == r_high_time);
    assign w_match_inc = match_inc(r_match_cnt, c_LOCK_M);

    always_comb begin
        w_state_nxt      = r_state;
        w_per_cnt_nxt    = r_per_cnt;
        w_high_cnt_nxt   = r_high_cnt;
        w_match_cnt_nxt  = r_match_cnt;
        w_period_nxt     = r_period;
        w_high_time_nxt  = r_high_time;
        w_meas_valid_nxt = 1'b0;
        w_locked_nxt     = r_locked;
        w_sat_err_nxt    = 1'b0;

        if (clr) begin
            w_state_nxt     = ST_SEEK;
            w_per_cnt_nxt   = '0;
            w_high_cnt_nxt  = '0;
            w_match_cnt_nxt = '0;
            w_locked_nxt    = 1'b0;
        end else begin
            case (r_state)
                ST_SEEK: begin
                    if (w_rise) begin
                        w_per_cnt_nxt  = c_CNT_ONE;
                        w_high_cnt_nxt = c_CNT_ONE;
                        w_state_nxt    = ST_MEAS;
                    end
                end
                ST_MEAS, ST_LOCK: begin
                    // Saturation wins over a coincident rise.
                    if (w_per_sat) begin
                        w_sat_err_nxt   = 1'b1;
                        w_locked_nxt    = 1'b0;
                        w_state_nxt     = ST_SEEK;
                        w_per_cnt_nxt   = '0;
                        w_high_cnt_nxt  = '0;
                        w_match_cnt_nxt = '0;
                    end else if (w_rise) begin
                        w_period_nxt     = r_per_cnt;
                        w_high_time_nxt  = r_high_cnt;
                        w_meas_valid_nxt = 1'b1;
                        w_per_cnt_nxt    = c_CNT_ONE;
                        w_high_cnt_nxt   = c_CNT_ONE;
                        // A zero match count means no previous valid measurement.
                        if ((r_match_cnt != '0) && w_same) begin
                            w_match_cnt_nxt = w_match_inc;
                            if (w_match_inc == c_LOCK_M) begin
                                w_locked_nxt = 1'b1;
                                w_state_nxt  = ST_LOCK;
                            end
                        end else begin
                            w_match_cnt_nxt = c_MATCH_1;
                            w_locked_nxt    = 1'b0;
                            w_state_nxt     = ST_MEAS;
                        end
                    end else begin
                        w_per_cnt_nxt = r_per_cnt + c_CNT_ONE;
                        if (w_sync) begin
                            w_high_cnt_nxt = r_high_cnt + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt     = ST_SEEK;
                    w_per_cnt_nxt   = '0;
                    w_high_cnt_nxt  = '0;
                    w_match_cnt_nxt = '0;
                    w_locked_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_SEEK;
            r_per_cnt    <= '0;
            r_high_cnt   <= '0;
            r_match_cnt  <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_sat_err    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_per_cnt    <= w_per_cnt_nxt;
            r_high_cnt   <= w_high_cnt_nxt;
            r_match_cnt  <= w_match_cnt_nxt;
            r_period     <= w_period_nxt;
            r_high_time  <= w_high_time_nxt;
            r_meas_valid <= w_meas_valid_nxt;
            r_locked     <= w_locked_nxt;
            r_sat_err    <= w_sat_err_nxt;
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;
    assign sat_err    = r_sat_err;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_detect.sv
// ============================================================================
// Module : tb_clk_div_detect
// Brief  : Scoreboard bench for clk_div_detect (CNT_W=8, LOCK_CNT=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_clk_div_detect;

    typedef struct packed {
        logic [7:0] per;
        logic [7:0] hi;
        logic       lk;
    } meas_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_in;
    logic       clr;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       meas_valid;
    logic       locked;
    logic       sat_err;

    meas_t exp_q[$];
    meas_t obs_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int sat_cnt = 0;
    int sat_cyc = 0;
    int mv_cyc = 0;
    int gen_rises = 0;

    // clk_in generator controls: immediate (cur_*) or at next period boundary (pend_*)
    int cur_h = 3;
    int cur_l = 3;
    bit cur_on = 1'b0;
    int ph = 0;
    int pend_h = 3;
    int pend_l = 3;
    bit pend_on = 1'b0;
    bit pend_async = 1'b0;
    bit pend_valid = 1'b0;
    bit async_mode = 1'b0;

    clk_div_detect #(
        .CNT_W    (8),
        .LOCK_CNT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_in     (clk_in),
        .clr        (clr),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .locked     (locked),
        .sat_err    (sat_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        bit nxt;
        clk_in = 1'b0;
        forever begin
            if (async_mode) begin
                clk_in = 1'b1;
                gen_rises++;
                #(37.3 + $urandom_range(0, 6));
                clk_in = 1'b0;
                #(27.3 + $urandom_range(0, 6));
            end else begin
                @(negedge clk);
                if (ph == 0 && pend_valid) begin
                    cur_on     = pend_on;
                    cur_h      = pend_h;
                    cur_l      = pend_l;
                    async_mode = pend_async;
                    pend_valid = 1'b0;
                end
                if (!async_mode) begin
                    nxt = cur_on && (ph < cur_h);
                    if (nxt && !clk_in) gen_rises++;
                    clk_in = nxt;
                    ph = (ph + 1) % (cur_h + cur_l);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (meas_valid) begin
            obs_q.push_back({period, high_time, locked});
            mv_cyc = cyc;
        end
        if (sat_err) begin
            sat_cnt++;
            sat_cyc = cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (obs_q.size() >= n) break;
            tick(1);
        end
        if (obs_q.size() >= n) ok = 1'b1;
    endtask

    task automatic start_div(input int h, input int l);
        cur_on = 1'b1;
        cur_h  = h;
        cur_l  = l;
        ph     = 0;
    endtask

    task automatic pend_div(input bit on, input int h, input int l, input bit asy);
        pend_on    = on;
        pend_h     = h;
        pend_l     = l;
        pend_async = asy;
        pend_valid = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        clr   = 1'b0;
        tick(3);
        n_vec++;
        if ({period, high_time} !== 16'h0) begin
            n_err++;
            $display("FAIL reset_data: got period=%0d high=%0d, want 0 0", period, high_time);
        end
        n_vec++;
        if ({meas_valid, locked, sat_err} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_flags: got mv/lk/sat=%b, want 000", {meas_valid, locked, sat_err});
        end
        reset = 1'b1;
        tick(10);
        n_vec++;
        if (obs_q.size() != 0 || sat_cnt != 0) begin
            n_err++;
            $display("FAIL idle_const: got %0d meas %0d sat, want 0 0", obs_q.size(), sat_cnt);
        end
    endtask

    task automatic test_div6;
        meas_t e, o;
        bit ok;
        obs_q.delete();
        exp_q.delete();
        start_div(3, 3);
        for (int i = 0; i < 6; i++) exp_q.push_back({8'd6, 8'd3, (i >= 3)});
        wait_obs(6, 200, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL div6_timeout: got %0d meas, want 6", obs_q.size());
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_err++;
                $display("FAIL div6_meas: got none, want per=%0d hi=%0d lk=%0b", e.per, e.hi, e.lk);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    n_err++;
                    $display("FAIL div6_meas: got per=%0d hi=%0d lk=%0b, want per=%0d hi=%0d lk=%0b",
                             o.per, o.hi, o.lk, e.per, e.hi, e.lk);
                end
            end
        end
    endtask

    task automatic test_div4_relock;
        meas_t e, o;
        bit ok;
        pend_div(1'b1, 2, 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            wait_obs(1, 40, ok);
            if (!ok || obs_q[0].per != 8'd6) break;
            o = obs_q.pop_front();
            n_vec++;
            if (o !== {8'd6, 8'd3, 1'b1}) begin
                n_err++;
                $display("FAIL div4_pre: got per=%0d hi=%0d lk=%0b, want 6 3 1", o.per, o.hi, o.lk);
            end
        end
        exp_q.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back({8'd4, 8'd2, (i >= 3)});
        wait_obs(5, 200, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL div4_timeout: got %0d meas, want 5", obs_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL div4_meas: got per=%0d hi=%0d lk=%0b, want per=%0d hi=%0d lk=%0b",
                         o.per, o.hi, o.lk, e.per, e.hi, e.lk);
            end
        end
    endtask

    task automatic test_saturation;
        meas_t o;
        bit ok;
        bit got_lock;
        int base;
        got_lock = 1'b0;
        obs_q.delete();
        pend_div(1'b1, 3, 3, 1'b0);
        for (int i = 0; i < 12 && !got_lock; i++) begin
            wait_obs(1, 40, ok);
            if (!ok) break;
            o = obs_q.pop_front();
            if (o === {8'd6, 8'd3, 1'b1}) got_lock = 1'b1;
        end
        n_vec++;
        if (!got_lock) begin
            n_err++;
            $display("FAIL sat_prelock: got lock=%0b, want 1", got_lock);
        end
        base = sat_cnt;
        pend_div(1'b0, 3, 3, 1'b0);
        for (int i = 0; i < 400 && sat_cnt == base; i++) tick(1);
        n_vec++;
        if (sat_cyc - mv_cyc != 255) begin
            n_err++;
            $display("FAIL sat_delay: got %0d cycles, want 255", sat_cyc - mv_cyc);
        end
        tick(300);
        n_vec++;
        if (sat_cnt - base != 1) begin
            n_err++;
            $display("FAIL sat_once: got %0d pulses, want 1", sat_cnt - base);
        end
        n_vec++;
        if ({locked, period, high_time} !== {1'b0, 8'd6, 8'd3}) begin
            n_err++;
            $display("FAIL sat_hold: got lk=%0b per=%0d hi=%0d, want 0 6 3", locked, period, high_time);
        end
        n_vec++;
        if (mv_cyc >= sat_cyc) begin
            n_err++;
            $display("FAIL sat_no_meas: got meas at %0d after sat at %0d, want none", mv_cyc, sat_cyc);
        end
    endtask

    task automatic test_clr;
        meas_t o;
        bit ok;
        bit got_lock;
        int base;
        got_lock = 1'b0;
        obs_q.delete();
        start_div(3, 3);
        for (int i = 0; i < 10 && !got_lock; i++) begin
            wait_obs(1, 40, ok);
            if (!ok) break;
            o = obs_q.pop_front();
            got_lock = o.lk;
        end
        clr = 1'b1;
        base = gen_rises;
        tick(1);
        n_vec++;
        if (locked !== 1'b0 || !got_lock) begin
            n_err++;
            $display("FAIL clr_unlock: got lk=%0b (prelock %0b), want 0 (1)", locked, got_lock);
        end
        clr = 1'b0;
        obs_q.delete();
        exp_q.push_back({8'd6, 8'd3, 1'b0});
        wait_obs(1, 40, ok);
        n_vec++;
        if (!ok || gen_rises - base != 2) begin
            n_err++;
            $display("FAIL clr_rises: got %0d rises before meas, want 2", gen_rises - base);
        end
        o = ok ? obs_q.pop_front() : '0;
        n_vec++;
        if (o !== exp_q[0]) begin
            n_err++;
            $display("FAIL clr_meas: got per=%0d hi=%0d lk=%0b, want 6 3 0", o.per, o.hi, o.lk);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_async_reset;
        meas_t o;
        bit ok;
        int base;
        obs_q.delete();
        wait_obs(1, 40, ok);
        obs_q.delete();
        #2;
        reset = 1'b0;
        #1;
        n_vec++;
        if ({period, high_time, meas_valid, locked, sat_err} !== 19'h0 || !ok) begin
            n_err++;
            $display("FAIL arst_zero: got per=%0d hi=%0d mv=%0b lk=%0b sat=%0b, want all 0",
                     period, high_time, meas_valid, locked, sat_err);
        end
        tick(1);
        reset = 1'b1;
        base = gen_rises;
        obs_q.delete();
        exp_q.push_back({8'd6, 8'd3, 1'b0});
        wait_obs(1, 40, ok);
        n_vec++;
        if (!ok || gen_rises - base != 2) begin
            n_err++;
            $display("FAIL arst_rises: got %0d rises before meas, want 2", gen_rises - base);
        end
        o = ok ? obs_q.pop_front() : '0;
        n_vec++;
        if (o !== exp_q[0]) begin
            n_err++;
            $display("FAIL arst_meas: got per=%0d hi=%0d lk=%0b, want 6 3 0", o.per, o.hi, o.lk);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_jitter;
        meas_t o;
        bit ok;
        int base;
        base = sat_cnt;
        pend_div(1'b1, 4, 3, 1'b1);
        tick(20);
        obs_q.delete();
        wait_obs(30, 400, ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL jit_timeout: got %0d meas, want 30", obs_q.size());
        end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            n_vec++;
            if (o.per < 8'd6 || o.per > 8'd8) begin
                n_err++;
                $display("FAIL jit_period: got per=%0d, want 6..8", o.per);
            end
        end
        n_vec++;
        if (sat_cnt != base) begin
            n_err++;
            $display("FAIL jit_sat: got %0d pulses, want 0", sat_cnt - base);
        end
    endtask

    initial begin
        test_reset();
        test_div6();
        test_div4_relock();
        test_saturation();
        test_clr();
        test_async_reset();
        test_jitter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/clk_div_detect.md
CLK_DIV_DETECT -- requirements
Module: clk_div_detect

Interface
REQ-001 Parameter CNT_W, default 8: width of the period and high-time counters and outputs.
REQ-002 Parameter LOCK_CNT, default 4: consecutive identical measurements required to assert locked; legal range 2..15.
REQ-003 The module SHALL have port clk, input, 1 bit: the single sampling clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port clk_in, input, 1 bit: the divided clock under measurement; asynchronous to clk.
REQ-006 The module SHALL have port clr, input, 1 bit: synchronous restart of measurement, active-high.
REQ-007 The module SHALL have port period, output, CNT_W bits: the last valid period, in clk cycles.
REQ-008 The module SHALL have port high_time, output, CNT_W bits: the last valid high time, in clk cycles.
REQ-009 The module SHALL have port meas_valid, output, 1 bit: one-cycle pulse when period and high_time update.
REQ-010 The module SHALL have port locked, output, 1 bit: LOCK_CNT consecutive identical measurements have been seen.
REQ-011 The module SHALL have port sat_err, output, 1 bit: one-cycle pulse when the period counter saturates.

Function
REQ-012 clk_in SHALL pass through a 2-flop synchronizer, then a history flop; rise = sync & ~hist; latency from clk_in edge to rise is 2-3 clk cycles.
REQ-013 FSM states SHALL be SEEK, MEAS and LOCK; after reset the state is SEEK.
REQ-014 SEEK: wait for rise; on rise clear the counters to 1 and go to MEAS.
REQ-015 MEAS/LOCK: each cycle without rise, the period counter SHALL increment, and the high counter SHALL increment when sync=1.
REQ-016 Period SHALL be the clk-cycle count between consecutive rises; high_time SHALL be the count of cycles with sync=1 in that window.
REQ-017 On rise in MEAS/LOCK, period and high_time SHALL load, and meas_valid SHALL pulse, in the cycle after rise; the counters SHALL restart at 1 on the same rise.
REQ-018 A measurement SHALL match when both period and high_time equal the previous valid values; match_cnt starts at 1 on the first measurement after SEEK.
REQ-019 Match: match_cnt SHALL increment, saturating at LOCK_CNT; on reaching LOCK_CNT, go to LOCK and assert locked from the same cycle as meas_valid.
REQ-020 Mismatch: match_cnt SHALL be set to 1, locked SHALL deassert, and the state SHALL go to MEAS; period and high_time still update.
REQ-021 Saturation: when the period counter equals 2^CNT_W-1 with no rise, sat_err SHALL pulse once, locked SHALL deassert, the state SHALL go to SEEK, and period and high_time SHALL hold.
REQ-022 A rise coinciding with saturation SHALL be treated as saturation, with no meas_valid.
REQ-023 clr SHALL take priority over rise: state to SEEK, counters and match_cnt to 0, locked=0; period and high_time hold.
REQ-024 A constant clk_in SHALL never produce meas_valid.

Reset
REQ-025 On reset=0, asynchronously: state SEEK, all counters 0, synchronizer flops 0, period=0, high_time=0, meas_valid=0, locked=0, sat_err=0.
REQ-026 Reset mid-measurement SHALL discard the partial measurement; the first measurement after release needs two rises.

Structure
REQ-027 The FSM state encoding and the default CNT_W and LOCK_CNT constants SHALL live in a shared package, clk_div_pkg.
REQ-028 The synchronizer plus edge detect SHALL be one sub-module, sync_edge (outputs sync, rise).

Verification
REQ-029 The bench SHALL cover: clk_in from a same-clock divide-by-6 (3 high, 3 low) -> period=6, high_time=3 every meas_valid; locked rises on the 4th meas_valid.
REQ-030 The bench SHALL cover: lock at divide-by-6, then switch to divide-by-4 (2/2) -> the first period=4 measurement drops locked; relock after 4 matching measurements.
REQ-031 The bench SHALL cover: clk_in held low after lock, CNT_W=8 -> sat_err pulses once 255 cycles after the last rise; locked=0; period stays 6.
REQ-032 The bench SHALL cover: clr pulsed mid-period while locked -> locked=0 next cycle; no meas_valid until two further rises.
REQ-033 The bench SHALL cover: reset asserted asynchronously mid-period -> all outputs 0 immediately; correct period=6 after release plus two rises.
REQ-034 The bench SHALL cover: divide-by-7 with 4 high, 3 low, clk_in asynchronous with jitter -> period within 7±1; locked may toggle, and sat_err never pulses.
